// File: rtl/core_ecc_enc.sv
// rtl/core_ecc_enc.sv - Hamming(7,4) transmit encoder with output FIFO and fault injection
module core_ecc_enc #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_dest,
  input  logic [3:0]       in_data,
  input  logic [2:0]       inj_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_pkt,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [OW-1:0] FULL_OCC = OW'(FIFO_DEPTH);

  logic [10:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic          run;
  logic          push;
  logic          pop;
  logic [6:0]    cw;
  logic [6:0]    flip;
  logic [10:0]   pkt_new;

  // cw = {d3, d2, d1, p4, d0, p2, p1}
  always_comb begin
    cw[0] = in_data[0] ^ in_data[1] ^ in_data[3];
    cw[1] = in_data[0] ^ in_data[2] ^ in_data[3];
    cw[2] = in_data[0];
    cw[3] = in_data[1] ^ in_data[2] ^ in_data[3];
    cw[4] = in_data[1];
    cw[5] = in_data[2];
    cw[6] = in_data[3];
    flip  = (inj_pos == 3'd0) ? 7'd0 : (7'd1 << (inj_pos - 3'd1));
    pkt_new = {in_dest, cw ^ flip};
  end

  // run holds in_ready low until the first edge after reset release
  assign in_ready  = run && (occ < FULL_OCC);
  assign out_valid = (occ != '0);
  assign out_pkt   = out_valid ? mem[rd_ptr] : 11'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pkt_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      pkt_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

endmodule
